// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared CIM constants, per-channel table sizes and sequencer state type
package cim_pkg;

    localparam int NUM_CHANNELS      = 6;
    localparam int MAX_FEATURE_WIDTH = 5;
    localparam int NUM_CHANNEL_WIDTH = 3;
    localparam int HV_DIMENSION      = 32;

    localparam int STOP_NUM_FEATURES    = 8;
    localparam int S_NUM_FEATURES       = 16;
    localparam int F_NUM_FEATURES       = 16;
    localparam int AMP_NUM_FEATURES     = 12;
    localparam int FORMANT_NUM_FEATURES = 20;

    // ch4 and ch5 index the same FORMANT table
    localparam int CIM_NUM_FEATURES [NUM_CHANNELS] = '{
        STOP_NUM_FEATURES, S_NUM_FEATURES, F_NUM_FEATURES,
        AMP_NUM_FEATURES, FORMANT_NUM_FEATURES, FORMANT_NUM_FEATURES
    };

    typedef enum logic [1:0] {IDLE, FETCH, STREAM} cim_seq_state_t;

    function automatic int cim_num_features(input logic [NUM_CHANNEL_WIDTH-1:0] ch);
        if (int'(ch) < NUM_CHANNELS)
            return CIM_NUM_FEATURES[ch];
        return 1;
    endfunction

endpackage

// File: rtl/cim_feature_clamp.sv
// rtl/cim_feature_clamp.sv - saturates a feature level to its channel's table size
module cim_feature_clamp
    import cim_pkg::*;
(
    input  logic [NUM_CHANNEL_WIDTH-1:0] ch,
    input  logic [MAX_FEATURE_WIDTH-1:0] level,
    output logic [MAX_FEATURE_WIDTH-1:0] level_clamped,
    output logic                         over
);
    localparam int LW = MAX_FEATURE_WIDTH + 1;

    logic [LW-1:0] limit;

    always_comb begin
        limit         = LW'(cim_num_features(ch));
        over          = ({1'b0, level} >= limit);
        level_clamped = over ? MAX_FEATURE_WIDTH'(limit - 1'b1) : level;
    end

endmodule

// File: rtl/cim_sequencer.sv
// rtl/cim_sequencer.sv - walks all channels of one feature vector through the item memory and streams the HVs
module cim_sequencer
    import cim_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      feat_valid,
    output logic                                      feat_ready,
    input  logic [NUM_CHANNELS*MAX_FEATURE_WIDTH-1:0] feat_data,
    output logic [MAX_FEATURE_WIDTH-1:0]              curr_feature,
    output logic [NUM_CHANNEL_WIDTH-1:0]              cim_fidx,
    input  logic [HV_DIMENSION-1:0]                   cim,
    output logic                                      hv_valid,
    input  logic                                      hv_ready,
    output logic [HV_DIMENSION-1:0]                   hv_data,
    output logic [NUM_CHANNEL_WIDTH-1:0]              hv_ch,
    output logic                                      hv_last,
    output logic                                      busy,
    output logic                                      clamp_err
);
    cim_seq_state_t                            state;
    logic [NUM_CHANNEL_WIDTH-1:0]              cur_ch;
    logic [NUM_CHANNELS*MAX_FEATURE_WIDTH-1:0] feat_reg;
    logic [NUM_CHANNEL_WIDTH-1:0]              addr_ch;
    logic [MAX_FEATURE_WIDTH-1:0]              raw_level;
    logic                                      over;
    logic                                      over_q;
    logic                                      accept;

    assign accept = (state == STREAM) && hv_valid && hv_ready;

    // Look one channel ahead on accept so the ROM register holds HV(cur_ch) in every STREAM cycle
    assign addr_ch   = (accept && !hv_last) ? cur_ch + 1'b1 : cur_ch;
    assign raw_level = feat_reg[int'(addr_ch)*MAX_FEATURE_WIDTH +: MAX_FEATURE_WIDTH];
    assign cim_fidx  = addr_ch;

    cim_feature_clamp u_clamp (
        .ch            (addr_ch),
        .level         (raw_level),
        .level_clamped (curr_feature),
        .over          (over)
    );

    assign hv_data = cim;
    assign hv_ch   = cur_ch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_ch     <= '0;
            feat_reg   <= '0;
            feat_ready <= 1'b0;
            hv_valid   <= 1'b0;
            hv_last    <= 1'b0;
            busy       <= 1'b0;
            clamp_err  <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            // over_q tracks the clamp status of the HV currently held by the ROM register
            over_q <= over;
            case (state)
                IDLE: begin
                    feat_ready <= 1'b1;
                    if (feat_valid && feat_ready) begin
                        feat_reg   <= feat_data;
                        cur_ch     <= '0;
                        feat_ready <= 1'b0;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    hv_valid <= 1'b1;
                    hv_last  <= (NUM_CHANNELS == 1);
                    state    <= STREAM;
                end
                STREAM: begin
                    if (accept) begin
                        if (over_q)
                            clamp_err <= 1'b1;
                        if (hv_last) begin
                            hv_valid   <= 1'b0;
                            hv_last    <= 1'b0;
                            busy       <= 1'b0;
                            feat_ready <= 1'b1;
                            cur_ch     <= '0;
                            state      <= IDLE;
                        end else begin
                            cur_ch  <= cur_ch + 1'b1;
                            hv_last <= (cur_ch == NUM_CHANNEL_WIDTH'(NUM_CHANNELS - 2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_sequencer.sv
// tb/tb_cim_sequencer.sv - directed self-checking bench for cim_sequencer with a registered golden ROM
module tb_cim_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        feat_valid;
    logic        feat_ready;
    logic [29:0] feat_data;
    logic [4:0]  curr_feature;
    logic [2:0]  cim_fidx;
    logic [31:0] cim;
    logic        hv_valid;
    logic        hv_ready;
    logic [31:0] hv_data;
    logic [2:0]  hv_ch;
    logic        hv_last;
    logic        busy;
    logic        clamp_err;

    int errors = 0;
    int checks = 0;
    bit clamp_exp = 1'b0;
    logic [31:0] captured [6];

    always #5 clk = ~clk;

    cim_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .feat_valid   (feat_valid),
        .feat_ready   (feat_ready),
        .feat_data    (feat_data),
        .curr_feature (curr_feature),
        .cim_fidx     (cim_fidx),
        .cim          (cim),
        .hv_valid     (hv_valid),
        .hv_ready     (hv_ready),
        .hv_data      (hv_data),
        .hv_ch        (hv_ch),
        .hv_last      (hv_last),
        .busy         (busy),
        .clamp_err    (clamp_err)
    );

    function automatic int lim_tab(input int ch);
        case (ch)
            0: return 8;
            1: return 16;
            2: return 16;
            3: return 12;
            default: return 20;
        endcase
    endfunction

    function automatic int base_tab(input int ch);
        case (ch)
            0: return 0;
            1: return 8;
            2: return 24;
            3: return 40;
            default: return 52;
        endcase
    endfunction

    function automatic logic [31:0] rom_word(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Golden item memory: one-cycle registered read
    always @(posedge clk)
        cim <= rom_word(base_tab(int'(cim_fidx)) + int'(curr_feature));

    function automatic logic [29:0] mkfeat(input int f0, input int f1, input int f2,
                                           input int f3, input int f4, input int f5);
        return {5'(f5), 5'(f4), 5'(f3), 5'(f2), 5'(f1), 5'(f0)};
    endfunction

    function automatic int raw_lv(input logic [29:0] fd, input int ch);
        return int'(fd[ch*5 +: 5]);
    endfunction

    function automatic int exp_level(input logic [29:0] fd, input int ch);
        int lv = raw_lv(fd, ch);
        return (lv >= lim_tab(ch)) ? lim_tab(ch) - 1 : lv;
    endfunction

    function automatic logic [31:0] exp_hv(input logic [29:0] fd, input int ch);
        return rom_word(base_tab(ch) + exp_level(fd, ch));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with feat_ready high; returns at the negedge after the last accept
    task automatic run_sample(input logic [29:0] fd, input int mode, input bit keep_valid);
        int beats = 0;
        int cyc = 0;
        int exp_addr;
        chk("pre_feat_ready", feat_ready, 1);
        feat_data  = fd;
        feat_valid = 1'b1;
        hv_ready   = 1'b0;
        @(negedge clk);
        chk("fetch_hv_valid", hv_valid, 0);
        chk("fetch_busy", busy, 1);
        chk("fetch_feat_ready", feat_ready, 0);
        if (keep_valid) feat_data = fd ^ 30'h2AAA_AAAA;
        else            feat_valid = 1'b0;
        while (beats < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            chk("hv_valid", hv_valid, 1);
            chk("hv_ch", hv_ch, beats);
            chk("hv_last", hv_last, beats == 5);
            chk("hv_data", hv_data, exp_hv(fd, beats));
            chk("clamp_err", clamp_err, clamp_exp);
            chk("stream_feat_ready", feat_ready, 0);
            captured[beats] = hv_data;
            hv_ready = (mode == 0) || (cyc % 3 == 1);
            #1;
            exp_addr = (hv_ready && beats < 5) ? beats + 1 : beats;
            chk("cim_fidx", cim_fidx, exp_addr);
            chk("curr_feature", curr_feature, exp_level(fd, exp_addr));
            if (hv_ready) begin
                if (raw_lv(fd, beats) >= lim_tab(beats)) clamp_exp = 1'b1;
                beats++;
            end
        end
        chk("beats_done", beats, 6);
        if (mode == 0) chk("stream_cycles", cyc, 6);
        @(negedge clk);
        hv_ready = 1'b0;
        chk("end_hv_valid", hv_valid, 0);
        chk("end_busy", busy, 0);
        chk("end_feat_ready", feat_ready, 1);
        chk("end_clamp_err", clamp_err, clamp_exp);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        feat_valid = 1'b0;
        feat_data  = '0;
        hv_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hv_valid", hv_valid, 0);
        chk("rst_hv_last", hv_last, 0);
        chk("rst_hv_ch", hv_ch, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clamp_err", clamp_err, 0);
        chk("rst_cim_fidx", cim_fidx, 0);
        chk("rst_curr_feature", curr_feature, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_feat_ready", feat_ready, 1);

        // 1: full-rate stream
        run_sample(mkfeat(0, 1, 2, 3, 4, 5), 0, 1'b0);
        // 2: stalls with ready pattern 1,0,0,1,...
        run_sample(mkfeat(0, 1, 2, 3, 4, 5), 1, 1'b0);
        // 3: ch2 over its table, clamps to 15 and sets the sticky error
        chk("pre_clamp_err", clamp_err, 0);
        run_sample(mkfeat(1, 2, 19, 3, 4, 5), 1, 1'b0);
        chk("clamp_err_set", clamp_err, 1);
        // 4: shared FORMANT table, sticky error persists
        run_sample(mkfeat(7, 9, 11, 11, 7, 7), 0, 1'b0);
        chk("formant_ch4", captured[4], rom_word(59));
        chk("formant_ch5", captured[5], rom_word(59));
        chk("clamp_err_sticky", clamp_err, 1);

        // 5: reset while ch3 is offered
        feat_data  = mkfeat(3, 3, 3, 3, 3, 3);
        feat_valid = 1'b1;
        hv_ready   = 1'b1;
        @(negedge clk);
        feat_valid = 1'b0;
        n = 0;
        while (!(hv_valid && hv_ch == 3'd3) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_ch3", hv_ch, 3);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        hv_ready  = 1'b0;
        clamp_exp = 1'b0;
        chk("abort_hv_valid", hv_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_clamp_err", clamp_err, 0);
        chk("abort_feat_ready", feat_ready, 0);
        @(negedge clk);
        chk("abort_feat_ready_back", feat_ready, 1);
        chk("abort_still_idle", hv_valid, 0);
        run_sample(mkfeat(6, 10, 13, 9, 17, 2), 0, 1'b0);

        // 6: feat_valid held high with changing data, back-to-back samples
        run_sample(mkfeat(2, 4, 6, 8, 10, 12), 0, 1'b1);
        run_sample(mkfeat(7, 15, 15, 11, 19, 0), 1, 1'b1);
        feat_valid = 1'b0;
        @(negedge clk);
        chk("final_idle_hv_valid", hv_valid, 0);
        chk("final_clamp_err", clamp_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
